// File: rtl/button_gesture.sv
// button_gesture: classifies debounced button activity into short, double and long presses,
// with auto-repeat strobes while a long press is held.
module button_gesture #(
    parameter int TICK_DIV  = 50000,
    parameter int LONG_MS   = 800,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 150,
    parameter int CNT_W     = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_down,
    input  logic pb_up,
    input  logic pb_state,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held,
    output logic busy
);
    localparam int PW = $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [CNT_W-1:0]   ms_q, ms_d;
    logic               dn, up, rel, tick, to_long, to_double, to_repeat, clr;
    logic               short_d, double_d, long_d, repeat_d;
    logic               short_q, double_q, long_q, repeat_q, held_q, busy_q;

    always_comb begin
        dn        = pb_down & ~pb_up;
        up        = pb_up & ~pb_down;
        // a dropped level without its pulse still counts as a release
        rel       = up | ~pb_state;
        tick      = pre_q == PW'(TICK_DIV - 1);
        to_long   = tick && ms_q == CNT_W'(LONG_MS - 1);
        to_double = tick && ms_q == CNT_W'(DOUBLE_MS - 1);
        to_repeat = tick && ms_q == CNT_W'(REPEAT_MS - 1);
        state_d   = state_q;
        short_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE:    if (dn) state_d = PRESS1;
            PRESS1:  if (rel) state_d = WAIT2;
                     else if (to_long) begin
                         state_d = LONG;
                         long_d  = 1'b1;
                     end
            WAIT2:   if (dn) state_d = PRESS2;
                     else if (to_double) begin
                         state_d = IDLE;
                         short_d = 1'b1;
                     end
            PRESS2:  if (rel) begin
                         state_d  = IDLE;
                         double_d = 1'b1;
                     end
            LONG:    if (rel) state_d = IDLE;
                     else repeat_d = to_repeat;
            default: state_d = IDLE;
        endcase
        clr  = (state_d != state_q) || repeat_d;
        pre_d = (clr || tick) ? '0 : pre_q + PW'(1);
        ms_d  = clr ? '0 : (tick && ~&ms_q) ? ms_q + CNT_W'(1) : ms_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            ms_q     <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= state_d == LONG;
            // busy stays up through the cycle that presents the gesture's final strobe
            busy_q   <= (state_d != IDLE) || short_d || double_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;
    assign held         = held_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: scoreboard bench; a cycle-timestamp gesture model queues expected strobes.
module tb_button_gesture;
    localparam int TD = 4, LM = 10, DM = 5, RM = 3;
    localparam int M_IDLE = 0, M_P1 = 1, M_W2 = 2, M_P2 = 3, M_LG = 4;

    logic clk = 0, rst_n = 0, pb_down = 0, pb_up = 0, pb_state = 0;
    logic short_press, double_press, long_press, repeat_pulse, held, busy;

    button_gesture #(.TICK_DIV(TD), .LONG_MS(LM), .DOUBLE_MS(DM), .REPEAT_MS(RM), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up), .pb_state(pb_state),
        .short_press(short_press), .double_press(double_press), .long_press(long_press),
        .repeat_pulse(repeat_pulse), .held(held), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int k;} ev_t;
    ev_t q[$];
    int checks = 0, errors = 0;
    int phase = M_IDLE, t0 = 0, base = 0;
    bit lvl = 0;
    logic exp_held = 0, exp_busy = 0;
    int last[4], first[4], nstrobe[4];
    string names[4] = '{"short_press", "double_press", "long_press", "repeat_pulse"};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Reference: phase plus entry cycle; a timeout of N ms fires on the N*TD-th cycle in the phase.
    task automatic apply(input bit d_i, input bit u_i, input bit s_i);
        bit d, u, r;
        int el, nxt, k;
        pb_down = d_i; pb_up = u_i; pb_state = s_i;
        d = d_i && !u_i; u = u_i && !d_i; r = u || !s_i;
        el = cyc - t0 + 1; nxt = phase; k = -1;
        case (phase)
            M_IDLE: if (d) nxt = M_P1;
            M_P1:   if (r) nxt = M_W2; else if (el == LM * TD) begin nxt = M_LG; k = 2; end
            M_W2:   if (d) nxt = M_P2; else if (el == DM * TD) begin nxt = M_IDLE; k = 0; end
            M_P2:   if (r) begin nxt = M_IDLE; k = 1; end
            default: if (r) nxt = M_IDLE; else if (el == RM * TD) k = 3;
        endcase
        if (nxt != phase || k == 3) t0 = cyc + 1;
        phase = nxt;
        if (k >= 0) q.push_back('{cyc + 1, k});
        exp_held = phase == M_LG;
        exp_busy = phase != M_IDLE || k == 0 || k == 1;
    endtask

    task automatic step(input bit d, input bit u, input bit s);
        @(negedge clk);
        apply(d, u, s);
    endtask

    task automatic idle(input int n, input bit s);
        repeat (n) step(0, 0, s);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) begin last[k] = -1; first[k] = -1; nstrobe[k] = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        phase = M_IDLE; exp_held = 0; exp_busy = 0; q.delete();
        #1 check("async_reset_outputs", {short_press, double_press, long_press, repeat_pulse, held, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        apply(0, 0, 0);
    endtask

    always @(posedge clk) begin
        logic [3:0] s;
        #1;
        s = {repeat_pulse, long_press, double_press, short_press};
        for (int k = 0; k < 4; k++) if (s[k]) begin
            last[k] = cyc; nstrobe[k]++;
            if (first[k] < 0) first[k] = cyc;
            checks++;
            if (q.size() > 0 && q[0].c == cyc && q[0].k == k) void'(q.pop_front());
            else begin
                errors++;
                $display("FAIL strobe_%s: got 1 at cycle %0d, required 0", names[k], cyc);
            end
        end
        while (q.size() > 0 && q[0].c <= cyc) begin
            checks++; errors++;
            $display("FAIL strobe_%s: got 0 at cycle %0d, required 1", names[q[0].k], q[0].c);
            void'(q.pop_front());
        end
        check("held", held, exp_held);
        check("busy", busy, exp_busy);
    end

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        check("reset_outputs", {short_press, double_press, long_press, repeat_pulse, held, busy}, 0);
        rst_n = 1;
        apply(0, 0, 0);
        idle(3, 0);
        // short press
        clear_stats();
        step(1, 0, 1); base = cyc; idle(7, 1); step(0, 1, 0); idle(30, 0);
        check("t1_short_cycle", last[0] - base, 29);
        check("t1_short_count", nstrobe[0], 1);
        check("t1_other_strobes", nstrobe[1] + nstrobe[2] + nstrobe[3], 0);
        // double press
        clear_stats();
        step(1, 0, 1); base = cyc; idle(7, 1); step(0, 1, 0); idle(6, 0);
        step(1, 0, 1); idle(4, 1); step(0, 1, 0); idle(30, 0);
        check("t2_double_cycle", last[1] - base, 21);
        check("t2_no_short", nstrobe[0], 0);
        // long press with repeats
        clear_stats();
        step(1, 0, 1); base = cyc; idle(69, 1); step(0, 1, 0); idle(30, 0);
        check("t3_long_cycle", last[2] - base, 41);
        check("t3_repeat_first", first[3] - base, 53);
        check("t3_repeat_last", last[3] - base, 65);
        check("t3_repeat_count", nstrobe[3], 2);
        // release on the long-timeout cycle
        clear_stats();
        step(1, 0, 1); base = cyc; idle(39, 1); step(0, 1, 0); idle(30, 0);
        check("t4a_no_long", nstrobe[2], 0);
        check("t4a_short_cycle", last[0] - base, 61);
        // second press on the double-window timeout cycle
        clear_stats();
        step(1, 0, 1); base = cyc; idle(7, 1); step(0, 1, 0); idle(19, 0);
        step(1, 0, 1); idle(3, 1); step(0, 1, 0); idle(30, 0);
        check("t4b_no_short", nstrobe[0], 0);
        check("t4b_double_cycle", last[1] - base, 33);
        // simultaneous pulses in IDLE
        clear_stats();
        step(1, 1, 0); step(0, 0, 0);
        check("t5a_busy", busy, 0);
        idle(10, 0);
        check("t5a_no_strobes", nstrobe[0] + nstrobe[1] + nstrobe[2] + nstrobe[3], 0);
        // missed release
        clear_stats();
        step(1, 0, 1); base = cyc; idle(7, 1); step(0, 0, 0); idle(30, 0);
        check("t5b_short_cycle", last[0] - base, 29);
        // reset mid-LONG, then a fresh short press
        step(1, 0, 1); idle(49, 1);
        check("t6_held_before_reset", held, 1);
        do_reset();
        idle(3, 0);
        clear_stats();
        step(1, 0, 1); base = cyc; idle(7, 1); step(0, 1, 0); idle(30, 0);
        check("t6_short_after_reset", last[0] - base, 29);
        check("t6_no_long", nstrobe[2], 0);
        // randomized gestures
        for (int i = 0; i < 150; i++) begin
            step(1, 0, 1);
            idle($urandom_range(0, 60), 1);
            if ($urandom_range(0, 9) == 0) step(0, 0, 0); else step(0, 1, 0);
            idle($urandom_range(0, 30), 0);
            if ($urandom_range(0, 14) == 0) step(1, 1, 0);
            if ($urandom_range(0, 39) == 0) do_reset();
        end
        idle(40, 0);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
